// File: rtl/writeback_stage_if.sv
// MA/WB pipeline-register inputs, ID read ports and redirect/writeback outputs of the
// final pipeline stage, bundled so the stage and its driver share one signal set.
interface writeback_stage_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       REGMrd;
    logic [WIDTH-1:0] REGMaluresult;
    logic [WIDTH-1:0] REGMbranchimm;
    logic [WIDTH-1:0] REGMpc;
    logic [WIDTH-1:0] REGMdmemdata;
    logic [WIDTH-1:0] REGMcsrrdata;
    logic [1:0]       REGMmem2reg;
    logic [1:0]       REGMpcsource;
    logic [1:0]       REGMbranchcntl;
    logic             REGMregwrite;
    logic             REGMzero;
    logic             WBstall;
    logic [4:0]       rs1addr;
    logic [4:0]       rs2addr;
    logic [WIDTH-1:0] rs1data;
    logic [WIDTH-1:0] rs2data;
    logic             pcredirect;
    logic [WIDTH-1:0] pctarget;
    logic             pipeflush;
    logic [WIDTH-1:0] wbvalue;
    logic             wbwe;

    modport slave (
        input  REGMrd, REGMaluresult, REGMbranchimm, REGMpc, REGMdmemdata, REGMcsrrdata,
               REGMmem2reg, REGMpcsource, REGMbranchcntl, REGMregwrite, REGMzero,
               WBstall, rs1addr, rs2addr,
        output rs1data, rs2data, pcredirect, pctarget, pipeflush, wbvalue, wbwe
    );

    modport master (
        output REGMrd, REGMaluresult, REGMbranchimm, REGMpc, REGMdmemdata, REGMcsrrdata,
               REGMmem2reg, REGMpcsource, REGMbranchcntl, REGMregwrite, REGMzero,
               WBstall, rs1addr, rs2addr,
        input  rs1data, rs2data, pcredirect, pctarget, pipeflush, wbvalue, wbwe
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: writeback mux, 32x32 register file with write-first read bypass,
// branch/jump resolution, and a counter-driven squash of the wrong-path shadow.
module writeback_stage #(
    parameter int WIDTH      = 32,
    parameter int SHADOW_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    writeback_stage_if.slave wb
);
    localparam int CW = (SHADOW_LEN > 1) ? $clog2(SHADOW_LEN) : 1;
    localparam logic [CW-1:0] RELOAD = (SHADOW_LEN > 0) ? CW'(SHADOW_LEN - 1) : '0;

    typedef enum logic {RUN, SHADOW} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rf_q [32];

    logic [WIDTH-1:0] wbvalue;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;
    logic             cond_true;
    logic             taken;
    logic             live;
    logic             we;
    logic             redirect;

    assign pc_plus4 = wb.REGMpc + WIDTH'(4);

    always_comb begin
        wbvalue = wb.REGMaluresult;
        case (wb.REGMmem2reg)
            2'b00:   wbvalue = wb.REGMaluresult;
            2'b01:   wbvalue = wb.REGMdmemdata;
            2'b10:   wbvalue = pc_plus4;
            default: wbvalue = wb.REGMcsrrdata;
        endcase
    end

    always_comb begin
        cond_true = 1'b0;
        case (wb.REGMbranchcntl)
            2'b00:   cond_true = wb.REGMzero;
            2'b01:   cond_true = ~wb.REGMzero;
            2'b10:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
        taken  = 1'b0;
        target = wb.REGMpc + wb.REGMbranchimm;
        case (wb.REGMpcsource)
            2'b01:   taken = cond_true;
            2'b10: begin
                taken  = 1'b1;
                target = wb.REGMaluresult & {{(WIDTH-1){1'b1}}, 1'b0};
            end
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Anything arriving while in SHADOW is wrong-path and has no architectural effect.
    assign live     = (state_q == RUN) && !wb.WBstall;
    assign we       = live && wb.REGMregwrite && (wb.REGMrd != 5'd0);
    assign redirect = live && taken;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            RUN: begin
                if (redirect && (SHADOW_LEN > 0)) begin
                    state_d = SHADOW;
                    count_d = RELOAD;
                end
            end
            default: begin
                if (!wb.WBstall) begin
                    if (count_q == '0) begin
                        state_d = RUN;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // x0 is never written because we already excludes rd==0, so it stays at its reset value.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rf
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rf_q[gi] <= '0;
            end else if (we && (wb.REGMrd == 5'(gi))) begin
                rf_q[gi] <= wbvalue;
            end
        end
    end

    assign wb.rs1data    = (we && (wb.rs1addr == wb.REGMrd)) ? wbvalue : rf_q[wb.rs1addr];
    assign wb.rs2data    = (we && (wb.rs2addr == wb.REGMrd)) ? wbvalue : rf_q[wb.rs2addr];
    assign wb.pcredirect = redirect;
    assign wb.pipeflush  = redirect;
    assign wb.pctarget   = target;
    assign wb.wbvalue    = wbvalue;
    assign wb.wbwe       = we;
endmodule
